// File: rtl/rf_writeback_queue_if.sv
// Handshake, drain and forwarding signals between the execute/memory stage,
// the write-back queue and the register file.
interface rf_writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_addr;
  logic [DATA_W-1:0] in_data;

  logic              rf_stall;
  logic              rf_we;
  logic [15:0]       rf_sel;
  logic [DATA_W-1:0] rf_data;

  logic [3:0]        fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport slave (
    input  in_valid, in_addr, in_data, rf_stall, fwd_addr,
    output in_ready, rf_we, rf_sel, rf_data, fwd_hit, fwd_data, count, empty, full
  );

  modport master (
    output in_valid, in_addr, in_data, rf_stall, fwd_addr,
    input  in_ready, rf_we, rf_sel, rf_data, fwd_hit, fwd_data, count, empty, full
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// Buffered write-back port for the 16 x 32-bit register file: FIFO of
// (addr, data) requests drained one per cycle, with a youngest-match forwarding lookup.
module rf_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_writeback_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [3:0]        r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [PTR_W-1:0]  w_idx;

  // in_ready depends only on registered occupancy, never on the pop.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = ~w_empty & ~bus.rf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_head        <= r_head + 1'b1;
        r_vld[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_tail        <= r_tail + 1'b1;
        r_vld[r_tail] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: the valid bits qualify every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.in_addr;
      r_data[r_tail] <= bus.in_data;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_vld[w_idx] && (r_addr[w_idx] == bus.fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign bus.in_ready = ~w_full;
  assign bus.rf_we    = w_pop;
  assign bus.rf_sel   = w_pop ? (16'(1) << r_addr[r_head]) : 16'h0000;
  assign bus.rf_data  = w_pop ? r_data[r_head] : '0;
  assign bus.fwd_hit  = w_fwd_hit;
  assign bus.fwd_data = w_fwd_data;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: directed vector table, corner-case
// sequences, then random traffic against a queue-based reference model.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rf_writeback_queue_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

  rf_writeback_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [31:0] d;
    logic        s;
    logic [3:0]  f;
    int          cnt;
    logic        we;
    logic [15:0] sel;
    logic [31:0] dat;
    logic        hit;
    logic [31:0] fwd;
  } vec_t;

  vec_t        tbl [10];
  logic [35:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                       input logic s, input logic [3:0] f);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.rf_stall = s;
    bus.fwd_addr = f;
  endtask

  task automatic exp_out(input string nm, input int cnt, input logic we,
                         input logic [15:0] sel, input logic [31:0] dat);
    chk({nm, " count"}, 32'(bus.count), cnt);
    chk({nm, " empty"}, 32'(bus.empty), 32'(cnt == 0));
    chk({nm, " full"}, 32'(bus.full), 32'(cnt == DEPTH));
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'(cnt != DEPTH));
    chk({nm, " rf_we"}, 32'(bus.rf_we), 32'(we));
    chk({nm, " rf_sel"}, 32'(bus.rf_sel), 32'(sel));
    chk({nm, " rf_data"}, bus.rf_data, dat);
  endtask

  task automatic exp_fwd(input string nm, input logic hit, input logic [31:0] dat);
    chk({nm, " fwd_hit"}, 32'(bus.fwd_hit), 32'(hit));
    chk({nm, " fwd_data"}, bus.fwd_data, dat);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd3, 32'hF0F0F0F0, 1'b0, 4'd3, 0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 1, 1'b1, 16'h0008, 32'hF0F0F0F0, 1'b1, 32'hF0F0F0F0};
    tbl[2] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 4'd5, 32'hAAAA0000, 1'b1, 4'd5, 0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 4'd5, 32'hBBBB1111, 1'b1, 4'd5, 1, 1'b0, 16'h0000, 32'h0, 1'b1, 32'hAAAA0000};
    tbl[5] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 2, 1'b0, 16'h0000, 32'h0, 1'b1, 32'hBBBB1111};
    tbl[6] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 2, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 2, 1'b1, 16'h0020, 32'hAAAA0000, 1'b1, 32'hBBBB1111};
    tbl[8] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 1, 1'b1, 16'h0020, 32'hBBBB1111, 1'b1, 32'hBBBB1111};
    tbl[9] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0};

    // Reset with a request present: nothing may be stored.
    drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd3);
    repeat (2) @(negedge clk);
    #1;
    exp_out("reset", 0, 1'b0, 16'h0, 32'h0);
    exp_fwd("reset", 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].f);
      #1;
      exp_out($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].we, tbl[i].sel, tbl[i].dat);
      exp_fwd($sformatf("vec%0d", i), tbl[i].hit, tbl[i].fwd);
    end

    // Fill under stall; the fifth request must be refused.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 4'(k), 32'h10 + 32'(k), 1'b1, 4'd0);
      #1;
      exp_out($sformatf("fill%0d", k), k, 1'b0, 16'h0, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd0);
    #1;
    exp_out("fill_hold", 4, 1'b0, 16'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
      #1;
      exp_out($sformatf("drain%0d", k), 4 - k, 1'b1, 16'(1) << k, 32'h10 + 32'(k));
    end
    @(negedge clk);
    #1;
    exp_out("drain_done", 0, 1'b0, 16'h0, 32'h0);

    // Simultaneous push and pop with count=2.
    @(negedge clk);
    drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd0);
    @(negedge clk);
    drive(1'b1, 4'd2, 32'h2, 1'b1, 4'd0);
    #1;
    exp_out("pp_setup", 1, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 4'd15, 32'hF0F0F0F1, 1'b0, 4'd0);
    #1;
    exp_out("pp0", 2, 1'b1, 16'h0002, 32'h1);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #1;
    exp_out("pp1", 2, 1'b1, 16'h0004, 32'h2);
    @(negedge clk);
    #1;
    exp_out("pp2", 1, 1'b1, 16'h8000, 32'hF0F0F0F1);
    @(negedge clk);
    #1;
    exp_out("pp3", 0, 1'b0, 16'h0, 32'h0);

    // Back-to-back pushes across several pointer wraps.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b1, 4'(k), 32'h100 + 32'(k), 1'b0, 4'd0);
      #1;
      if (k == 0) exp_out("wrap0", 0, 1'b0, 16'h0, 32'h0);
      else exp_out($sformatf("wrap%0d", k), 1, 1'b1, 16'(1) << (k - 1), 32'h100 + 32'(k - 1));
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #1;
    exp_out("wrap_last", 1, 1'b1, 16'h0200, 32'h109);
    @(negedge clk);
    #1;
    exp_out("wrap_done", 0, 1'b0, 16'h0, 32'h0);

    // Asynchronous reset between edges with three entries queued.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 4'd7 + 4'(k), 32'h70 + 32'(k), 1'b1, 4'd7);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd7);
    #1;
    exp_out("arst_pre", 3, 1'b1, 16'h0080, 32'h70);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out("arst_now", 0, 1'b0, 16'h0, 32'h0);
    exp_fwd("arst_now", 1'b0, 32'h0);
    drive(1'b1, 4'd9, 32'h99, 1'b0, 4'd9);
    repeat (2) @(negedge clk);
    #1;
    exp_out("arst_hold", 0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd7);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      exp_out($sformatf("arst_post%0d", k), 0, 1'b0, 16'h0, 32'h0);
      exp_fwd($sformatf("arst_post%0d", k), 1'b0, 32'h0);
    end

    // Random traffic against a plain FIFO model.
    q.delete();
    for (int n = 0; n < 400; n++) begin
      logic        v, s, e_we, e_hit, push;
      logic [3:0]  a, f;
      logic [31:0] d, e_fwd, e_dat;
      logic [15:0] e_sel;
      @(negedge clk);
      v = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 9) < 3);
      a = 4'($urandom_range(0, 15));
      f = 4'($urandom_range(0, 15));
      d = $urandom;
      drive(v, a, d, s, f);
      #1;
      e_we  = (q.size() > 0) && !s;
      e_sel = e_we ? (16'(1) << q[0][35:32]) : 16'h0;
      e_dat = e_we ? q[0][31:0] : 32'h0;
      e_hit = 1'b0;
      e_fwd = 32'h0;
      foreach (q[j]) begin
        if (q[j][35:32] == f) begin
          e_hit = 1'b1;
          e_fwd = q[j][31:0];
        end
      end
      exp_out($sformatf("rnd%0d", n), q.size(), e_we, e_sel, e_dat);
      exp_fwd($sformatf("rnd%0d", n), e_hit, e_fwd);
      push = v && (q.size() < DEPTH);
      @(posedge clk);
      if (e_we) void'(q.pop_front());
      if (push) q.push_back({a, d});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Buffered write-back port for the 16 x 32-bit ARM register file.
- Accepts (register address, data) write requests from the execute/memory stage over a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle into the register file as a one-hot write-select vector plus data; the select vector drives the register enables directly.
- Provides a combinational forwarding lookup so read-port logic can see queued values that have not yet been written.

Parameters:
- DATA_W, 32, width of register data.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_addr  input  4  destination register R0..R15.
- in_data  input  DATA_W  value to write.
- rf_stall  input  1  register file busy; hold the drain.
- rf_we  output  1  register-file write strobe.
- rf_sel  output  16  one-hot register select; all zero when rf_we=0.
- rf_data  output  DATA_W  write data; 0 when rf_we=0.
- fwd_addr  input  4  register being read.
- fwd_hit  output  1  a queued entry targets fwd_addr.
- fwd_data  output  DATA_W  data of the youngest matching entry; 0 when no hit.
- count  output  CNT_W  current occupancy.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Reset is asynchronous on rst_n low and clears:
  - head/tail pointers and count to 0;
  - all entry valid bits.
- While reset is asserted: empty=1, full=0, in_ready=1, rf_we=0, rf_sel=0, rf_data=0, fwd_hit=0, fwd_data=0.
- Requests presented during reset are not stored.
- Reset asserted mid-drain discards all queued entries; no partial write is emitted after release.
- Push:
  - in_ready = !full, combinational from registered state only.
  - There is no path from rf_stall or the pop to in_ready, so a full queue refuses a push even in a cycle where it pops.
  - On a clk edge with in_valid & in_ready, store {in_addr, in_data} at the tail; tail advances modulo DEPTH.
- Drain:
  - rf_we = !empty & !rf_stall, combinational.
  - rf_sel = 1 << head.addr, and rf_data = head.data, when rf_we=1.
  - On a clk edge with rf_we=1 the head entry is popped; head advances modulo DEPTH.
- Latency: an entry accepted at edge N first appears on rf_we/rf_sel in the cycle after edge N. There is no same-cycle bypass from in_* to rf_*.
- Ordering is strict FIFO. Two queued writes to the same register are both emitted, in order.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Simultaneous pop of the last entry and push: the queue stays non-empty, and the new entry drains in the next cycle.
- count updates:
  - +1 on push only;
  - -1 on pop only;
  - unchanged otherwise.
- count never exceeds DEPTH or goes below 0.
- Forwarding:
  - Purely combinational over all valid entries, including the head being drained in the current cycle.
  - Uses the youngest (closest to tail) matching entry.
  - Does not consider the in_* request of the current cycle.
- in_addr = 15 (PC) is queued and written like any other register; there is no special casing.
- rf_stall held high blocks the drain indefinitely. The queue fills to DEPTH, then in_ready drops.

Test Plan:
- Reset, then single push: in_addr=3, in_data=0xF0F0F0F0 at edge 1 -> cycle after edge 1: rf_we=1, rf_sel=0x0008, rf_data=0xF0F0F0F0; after edge 2: empty=1, rf_we=0, rf_sel=0.
- rf_stall=1 with 5 pushes R0..R4, data 0x10..0x14 -> after 4 accepts: full=1, count=4, in_ready=0; 5th request is not accepted; then release rf_stall -> rf_sel = 0x0001, 0x0002, 0x0004, 0x0008 on four consecutive cycles, data 0x10..0x13.
- Forwarding priority: with rf_stall=1, queue R5=0xAAAA0000 then R5=0xBBBB1111; fwd_addr=5 -> fwd_hit=1, fwd_data=0xBBBB1111; fwd_addr=6 -> fwd_hit=0, fwd_data=0.
- Simultaneous push/pop: count=2, rf_stall=0, push R15=0xF0F0F0F1 -> count stays 2, drain order preserved, R15 emitted as rf_sel=0x8000 two cycles later.
- Pointer wrap: 10 back-to-back pushes with rf_stall=0 and addresses cycling 0..9 -> rf_sel sequence matches push order exactly, count never exceeds 1, no entry lost across a tail wrap at DEPTH.
- Asynchronous reset mid-operation: rst_n low between edges with count=3 -> rf_we=0 and count=0 immediately (before the next edge); after release, no stale writes are emitted.
